// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and the
// control-unit decoder that launches it.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_e;

  typedef enum logic [0:0] {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's complement negate: o_data = i_neg ? -i_data : i_data.
module sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_negated;

  assign w_negated = (~i_data) + {{(WIDTH-1){1'b0}}, 1'b1};
  assign o_data    = i_neg ? w_negated : i_data;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / divide with architectural HI/LO registers.
// Works on magnitudes (shift-add / restoring division) and fixes signs at FIN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  md_op_e             r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;

  logic               w_take_mult;
  logic               w_take_div;
  logic               w_div_by_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .i_neg  (A[WIDTH-1]),
    .i_data (A),
    .o_data (w_mag_a)
  );

  sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .i_neg  (B[WIDTH-1]),
    .i_data (B),
    .o_data (w_mag_b)
  );

  sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg  (r_neg_q),
    .i_data ({r_acc_hi, r_acc_lo}),
    .o_data (w_prod_fix)
  );

  sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg  (r_neg_q),
    .i_data (r_acc_lo),
    .o_data (w_quo_fix)
  );

  sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg  (r_neg_r),
    .i_data (r_acc_hi),
    .o_data (w_rem_fix)
  );

  // Multiply step: add multiplicand when the current multiplier bit is set, then shift right.
  assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  // Divide step: bring in the next dividend bit and trial-subtract the divisor.
  assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_sub   = WIDTH'(w_shift - {1'b0, r_opb});

  // Next-state decode and start arbitration (multiply wins over divide).
  always_comb begin
    w_state_nxt   = r_state;
    w_take_mult   = 1'b0;
    w_take_div    = 1'b0;
    w_div_by_zero = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mult_start) begin
          w_take_mult = 1'b1;
          w_state_nxt = ST_MULT;
        end else if (div_start) begin
          if (B == {WIDTH{1'b0}}) begin
            w_div_by_zero = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_take_div  = 1'b1;
            w_state_nxt = ST_DIV;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MULT, ST_DIV: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_MULT;
      r_cnt      <= {CNT_W{1'b0}};
      r_acc_hi   <= {WIDTH{1'b0}};
      r_acc_lo   <= {WIDTH{1'b0}};
      r_opb      <= {WIDTH{1'b0}};
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take_mult || w_take_div) begin
            r_op     <= w_take_mult ? OP_MULT : OP_DIV;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= w_mag_a;
            r_opb    <= w_mag_b;
            r_neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r  <= A[WIDTH-1];
            r_busy   <= 1'b1;
          end else if (w_div_by_zero) begin
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end
        end
        ST_MULT: begin
          r_acc_hi <= w_sum[WIDTH:1];
          r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_DIV: begin
          r_acc_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
          r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_FIN: begin
          if (r_op == OP_MULT) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS multicycle datapath. It sits directly downstream of the control unit, which asserts a one-cycle start for MULT/DIV and then waits on `done`. The unit keeps the architectural HI/LO registers, and the datapath reads them for MFHI/MFLO. A divide-by-zero flag feeds back to the control unit's exception path.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `mult_start`  in  1  start signed multiply (control unit, one-cycle pulse).
- `div_start`  in  1  start signed divide (one-cycle pulse).
- `A`  in  WIDTH  operand A / dividend, from register A.
- `B`  in  WIDTH  operand B / divisor, from register B.
- `HI`  out  WIDTH  mult: product[63:32]; div: remainder.
- `LO`  out  WIDTH  mult: product[31:0]; div: quotient.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: result written, or div-by-zero reported.
- `div_zero`  out  1  valid only with `done`; 1 = divide by zero.

## Operation
- States: IDLE, MULT, DIV, FIN.
- IDLE:
  - On `mult_start`, latch |A| and |B| and the result sign (A[31]^B[31]), then go to MULT.
  - On `div_start` with B≠0, latch magnitudes, quotient sign (A^B) and remainder sign (A[31]), then go to DIV.
  - On `div_start` with B=0, assert `done` and `div_zero`, stay in IDLE, leave HI/LO unchanged.
  - If both starts are asserted, `mult_start` wins.
- MULT: unsigned shift-add of the magnitudes, one bit per cycle, 32 iterations, into a 64-bit accumulator.
- DIV: restoring division of the magnitudes, one quotient bit per cycle, 32 iterations.
- Counter: 5 bits, cleared on start. After iteration 31, go to FIN.
- FIN:
  - Apply the sign as two's complement negation when the sign bit is 1.
  - Write HI/LO, pulse `done`, return to IDLE.
- Width and edge rules:
  - Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000 exactly.
  - Product is the full 64 bits.
  - Division truncates toward zero. The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0 (wraps, no flag).
- Starts while `busy` are ignored. Operands are not re-sampled mid-operation.
- HI/LO change only at FIN or reset. They hold between operations.

## Timing
- Reset values: `HI`=0, `LO`=0, `busy`=0, `done`=0, `div_zero`=0. State is IDLE and the counter is 0.
- Start accepted at edge E0.
  - `busy`=1 after E0.
  - Iterations run on E1..E32.
  - E33 (FIN) writes HI/LO, sets `done`=1 and `busy`=0.
  - `done` clears at E34.
  - Latency is 33 cycles from the start edge to a valid result.
- Divide by zero: start edge E0 sets `done`=`div_zero`=1 after E0, and both clear at E1. `busy` never rises.
- A new start is accepted in the cycle `done` is high, because the unit is already in IDLE.
- Reset during any state aborts the operation at that edge:
  - All outputs go to their reset values, including HI/LO=0.
  - No `done` is produced.
  - Reset has priority over starts in the same cycle.

## Structure
- Shared definitions file holds:
  - State encodings (2-bit).
  - MIPS funct constants MULT=6'h18, DIV=6'h1A, MFHI=6'h10, MFLO=6'h12, also used by the control unit decoder.
- Sub-module `sign_fix`: combinational conditional two's complement negate, parameterised width. Instantiate it once for operand magnitudes and once for result sign correction.

## Test plan
- mult A=7, B=0xFFFFFFFD (-3) -> after E33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` high exactly one cycle; `busy` high E1..E33.
- mult A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then div 100/7 -> LO=14, HI=2.
- Preload HI/LO by a multiply, then div A=5, B=0 -> `done`=`div_zero`=1 in the cycle after the start edge; HI/LO unchanged; `busy` stays 0.
- Reset asserted at iteration 10 of a multiply -> next edge: `busy`=0, HI=LO=0, no `done`; a following mult 3×4 gives LO=12, HI=0.
- `div_start` pulsed at iteration 5 of a multiply -> ignored, multiply result correct. Simultaneous `mult_start`/`div_start` with A=6, B=3 -> LO=18.
